// File: rtl/seg7_scan_reader_pkg.sv
// Shared definitions for the seven-segment scan reader: glyph constants, the
// invalid-digit code and the frame FSM state type.
package seg7_scan_reader_pkg;

    // Segment patterns {a,b,c,d,e,f,g}, a in bit 6, active-high.
    // The BCD-to-7seg encoder on the driving side uses the same constants.
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    // Code reported for a pattern that is not a legal 0-9 glyph.
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StPresent = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_reader_glyph_decode.sv
// Combinational seven-segment glyph to BCD decoder. Anything that is not an
// exact 0-9 glyph decodes to BCD_INVALID with err_o set.
module seg7_glyph_decode
    import seg7_scan_reader_pkg::*;
(
    input  logic [6:0] y_i,
    output logic [3:0] bcd_o,
    output logic       err_o
);

    // Glyph lookup table.
    always_comb begin
        bcd_o = BCD_INVALID;
        err_o = 1'b0;
        case (y_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: begin
                bcd_o = BCD_INVALID;
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed seven-segment display bus. Synchronises the
// anode and segment lines, waits for each digit to settle, decodes it back to
// BCD and hands complete frames downstream over valid/ready.
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              Y,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int unsigned          SAMPLE_W   = NUM_DIGITS + 7;
    localparam int unsigned          CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     STABLE_MAX = CNT_W'(STABLE_CYCLES);

    // Synchroniser chains.
    logic [NUM_DIGITS-1:0] an_sync_q [SYNC_STAGES];
    logic [6:0]            y_sync_q  [SYNC_STAGES];

    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            y_s;
    logic [SAMPLE_W-1:0]   sample;
    logic [SAMPLE_W-1:0]   prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  an_onehot;
    logic                  same;
    logic                  capture;

    logic [3:0]            dec_bcd;
    logic                  dec_err;

    logic [4*NUM_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_merged;
    logic                    complete;

    scan_state_e state_q;

    // Input synchroniser: every downstream decision uses the last stage only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                an_sync_q[s] <= '0;
                y_sync_q[s]  <= '0;
            end
        end else begin
            an_sync_q[0] <= an;
            y_sync_q[0]  <= Y;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                an_sync_q[s] <= an_sync_q[s-1];
                y_sync_q[s]  <= y_sync_q[s-1];
            end
        end
    end

    assign an_s      = an_sync_q[SYNC_STAGES-1];
    assign y_s       = y_sync_q[SYNC_STAGES-1];
    assign sample    = {an_s, y_s};
    assign an_onehot = $onehot(an_s);
    assign same      = (sample == prev_q);

    // Stability counter: restarts at 1 on any change, saturates, and is
    // parked at 0 while the anode lines are not one-hot.
    always_comb begin
        cnt_d = '0;
        if (an_onehot) begin
            if (!same) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q < STABLE_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Fire once per stable run; the !same term covers STABLE_CYCLES == 1,
    // where the counter is already saturated when a new run starts.
    assign capture = an_onehot && (cnt_d == STABLE_MAX) && (!same || (cnt_q != STABLE_MAX));

    // Stability tracking state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= sample;
            cnt_q  <= cnt_d;
        end
    end

    seg7_glyph_decode u_decode (
        .y_i   (y_s),
        .bcd_o (dec_bcd),
        .err_o (dec_err)
    );

    // Slot contents with this cycle's capture merged in, so a completing
    // capture is included in the frame it completes.
    always_comb begin
        slot_bcd_d = slot_bcd_q;
        slot_err_d = slot_err_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (capture && an_s[i]) begin
                slot_bcd_d[4*i +: 4] = dec_bcd;
                slot_err_d[i]        = dec_err;
            end
        end
    end

    assign seen_merged = capture ? (seen_q | an_s) : seen_q;
    assign complete    = capture && (&seen_merged);

    // Digit slots and the per-frame seen mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_bcd_q <= '0;
            slot_err_q <= '0;
            seen_q     <= '0;
        end else begin
            slot_bcd_q <= slot_bcd_d;
            slot_err_q <= slot_err_d;
            seen_q     <= complete ? '0 : seen_merged;
        end
    end

    // Frame FSM and handshake; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCollect;
            frame_bcd   <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state_q)
                StCollect: begin
                    if (complete) begin
                        frame_bcd   <= slot_bcd_d;
                        frame_err   <= slot_err_d;
                        frame_valid <= 1'b1;
                        state_q     <= StPresent;
                    end
                end
                StPresent: begin
                    if (frame_ready) begin
                        overrun <= 1'b0;
                        // Accept and completion together: hand over the new
                        // frame directly without a gap in frame_valid.
                        if (complete) begin
                            frame_bcd <= slot_bcd_d;
                            frame_err <= slot_err_d;
                        end else begin
                            frame_valid <= 1'b0;
                            state_q     <= StCollect;
                        end
                    end else if (complete) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StCollect;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  Y;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .Y           (Y),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic show(input int d, input logic [6:0] g, input int cycles);
        an = 4'b0001 << d;
        Y  = g;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle();
        an = 4'b0000;
        Y  = 7'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!frame_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (frame_valid !== 1'b1)
            $display("FAIL wait_valid: frame_valid=%b required 1 within %0d cycles",
                     frame_valid, max_cycles);
        else n_pass++;
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0)
            $display("FAIL %s_accept_valid: frame_valid=%b required 0", tag, frame_valid);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b0)
            $display("FAIL %s_accept_overrun: overrun=%b required 0", tag, overrun);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        an          = 4'b0000;
        Y           = 7'h00;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", frame_valid);
        else n_pass++;
        n_checks++;
        if (frame_bcd !== 16'h0000) $display("FAIL reset_bcd: got %h required 0000", frame_bcd);
        else n_pass++;
        n_checks++;
        if (frame_err !== 4'b0000) $display("FAIL reset_err: got %b required 0000", frame_err);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b required 0", overrun);
        else n_pass++;
    endtask

    task automatic test_basic();
        show(0, 7'h30, 8);
        show(1, 7'h6D, 8);
        show(2, 7'h79, 8);
        show(3, 7'h33, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (frame_bcd !== 16'h4321) $display("FAIL basic_bcd: got %h required 4321", frame_bcd);
        else n_pass++;
        n_checks++;
        if (frame_err !== 4'b0000) $display("FAIL basic_err: got %b required 0000", frame_err);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b1 || frame_bcd !== 16'h4321)
            $display("FAIL basic_hold: valid=%b bcd=%h required 1/4321", frame_valid, frame_bcd);
        else n_pass++;
        accept("basic");
    endtask

    task automatic test_glitch();
        show(0, 7'h30, 8);
        show(1, 7'h7E, 3);
        show(1, 7'h7F, 5);
        show(2, 7'h79, 8);
        show(3, 7'h33, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (frame_bcd !== 16'h4381) $display("FAIL glitch_bcd: got %h required 4381", frame_bcd);
        else n_pass++;
        n_checks++;
        if (frame_err !== 4'b0000) $display("FAIL glitch_err: got %b required 0000", frame_err);
        else n_pass++;
        accept("glitch");
    endtask

    task automatic test_illegal();
        show(0, 7'h30, 8);
        show(1, 7'h6D, 8);
        show(2, 7'h01, 8);
        show(3, 7'h33, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (frame_bcd !== 16'h4F21) $display("FAIL illegal_bcd: got %h required 4f21", frame_bcd);
        else n_pass++;
        n_checks++;
        if (frame_err !== 4'b0100) $display("FAIL illegal_err: got %b required 0100", frame_err);
        else n_pass++;
        accept("illegal");
    endtask

    task automatic test_overrun();
        show(0, 7'h5B, 8);
        show(1, 7'h5F, 8);
        show(2, 7'h70, 8);
        show(3, 7'h7F, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_first: got %b required 0", overrun);
        else n_pass++;
        show(0, 7'h7B, 8);
        show(1, 7'h7E, 8);
        show(2, 7'h30, 8);
        show(3, 7'h6D, 8);
        idle();
        n_checks++;
        if (frame_valid !== 1'b1) $display("FAIL overrun_valid: got %b required 1", frame_valid);
        else n_pass++;
        n_checks++;
        if (frame_bcd !== 16'h8765) $display("FAIL overrun_bcd: got %h required 8765", frame_bcd);
        else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b required 1", overrun);
        else n_pass++;
        accept("overrun");
        repeat (6) @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0)
            $display("FAIL overrun_no_reload: frame_valid=%b required 0", frame_valid);
        else n_pass++;
    endtask

    task automatic test_no_onehot();
        logic saw_valid = 1'b0;
        an = 4'b0000;
        Y  = 7'h30;
        repeat (20) begin
            @(negedge clk);
            saw_valid |= frame_valid;
        end
        an = 4'b0011;
        Y  = 7'h30;
        repeat (20) begin
            @(negedge clk);
            saw_valid |= frame_valid;
        end
        n_checks++;
        if (saw_valid !== 1'b0) $display("FAIL nohot_valid: saw valid=%b required 0", saw_valid);
        else n_pass++;
        // Slot 0 must still be missing, so three digits cannot finish a frame.
        show(1, 7'h6D, 8);
        show(2, 7'h79, 8);
        show(3, 7'h33, 8);
        idle();
        n_checks++;
        if (frame_valid !== 1'b0)
            $display("FAIL nohot_partial: frame_valid=%b required 0", frame_valid);
        else n_pass++;
        show(0, 7'h30, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (frame_bcd !== 16'h4321) $display("FAIL nohot_bcd: got %h required 4321", frame_bcd);
        else n_pass++;
        accept("nohot");
    endtask

    task automatic test_reset_mid();
        show(0, 7'h30, 8);
        show(1, 7'h6D, 8);
        show(2, 7'h79, 8);
        reset = 1'b1;
        an    = 4'b0000;
        Y     = 7'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL midrst_clear: valid=%b overrun=%b required 0/0", frame_valid, overrun);
        else n_pass++;
        show(3, 7'h5F, 8);
        idle();
        n_checks++;
        if (frame_valid !== 1'b0)
            $display("FAIL midrst_partial: frame_valid=%b required 0", frame_valid);
        else n_pass++;
        show(2, 7'h70, 8);
        show(1, 7'h7F, 8);
        show(0, 7'h7B, 8);
        idle();
        wait_valid(20);
        n_checks++;
        if (frame_bcd !== 16'h6789) $display("FAIL midrst_bcd: got %h required 6789", frame_bcd);
        else n_pass++;
        n_checks++;
        if (frame_err !== 4'b0000) $display("FAIL midrst_err: got %b required 0000", frame_err);
        else n_pass++;
        accept("midrst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_illegal();
        test_overrun();
        test_no_onehot();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
